// File: rtl/zl_ts_defs.sv
// Shared transport stream definitions for the TS byte path.
// Sync/length constants, null packet bytes and the inserter state encoding.
package zl_ts_defs;

    localparam logic [7:0]  TS_SYNC     = 8'h47;
    localparam int unsigned TS_PKT_LEN  = 188;
    localparam logic [7:0]  TS_LAST_IDX = 8'd187;

    localparam logic [7:0] NULL_HDR_1 = 8'h1F;
    localparam logic [7:0] NULL_HDR_2 = 8'hFF;
    localparam logic [7:0] NULL_HDR_3 = 8'h10;
    localparam logic [7:0] NULL_FILL  = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_NULL,
        ST_RESYNC
    } ts_state_e;

    // Byte idx of a DVB null packet (PID 0x1FFF, payload-only, all 0xFF).
    function automatic logic [7:0] null_byte(input logic [7:0] idx);
        logic [7:0] b;
        b = NULL_FILL;
        unique case (1'b1)
            idx == 8'd0: b = TS_SYNC;
            idx == 8'd1: b = NULL_HDR_1;
            idx == 8'd2: b = NULL_HDR_2;
            idx == 8'd3: b = NULL_HDR_3;
            default:     b = NULL_FILL;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/zl_ts_null_inserter.sv
// Packet-aligned FIFO reader: forwards whole 188-byte TS packets, or emits
// a null packet when a full one is not buffered; re-acquires 0x47 sync.
//   in_req/in_ack/in_data/in_used/in_full : show-ahead FIFO read side
//   out_req/out_ack/out_data              : downstream byte stream
//   out_pkt_start, out_is_null            : packet framing flags
//   null_cnt, sync_err_cnt                : wrapping event counters
module zl_ts_null_inserter
    import zl_ts_defs::*;
#(
    parameter int Addr_width = 0,
    // Keeps the port legal at the unusable default of 0.
    localparam int Used_w = (Addr_width < 1) ? 1 : Addr_width
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_req,
    output logic              in_ack,
    input  logic [7:0]        in_data,
    input  logic [Used_w-1:0] in_used,
    input  logic              in_full,
    output logic              out_req,
    input  logic              out_ack,
    output logic [7:0]        out_data,
    output logic              out_pkt_start,
    output logic              out_is_null,
    output logic [15:0]       null_cnt,
    output logic [15:0]       sync_err_cnt
);

    ts_state_e   state_q, state_d;
    logic [7:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] null_cnt_q, sync_err_cnt_q;
    logic        null_inc, sync_inc;
    logic        avail, last, sync_ok;

    // in_used wraps to 0 when the FIFO is completely full.
    assign avail   = in_full || (32'(in_used) >= TS_PKT_LEN);
    assign last    = (byte_cnt_q == TS_LAST_IDX);
    assign sync_ok = (in_data == TS_SYNC);

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        out_req    = 1'b0;
        in_ack     = 1'b0;
        out_data   = 8'h00;
        null_inc   = 1'b0;
        sync_inc   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                byte_cnt_d = 8'd0;
                state_d    = avail ? ST_PASS : ST_NULL;
            end
            ST_PASS: begin
                if (in_req && byte_cnt_q == 8'd0 && !sync_ok) begin
                    state_d  = ST_RESYNC;
                    sync_inc = 1'b1;
                end else begin
                    out_req  = in_req;
                    out_data = in_data;
                    in_ack   = in_req && out_ack;
                    if (in_req && out_ack) begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                        if (last) state_d = ST_IDLE;
                    end
                end
            end
            ST_NULL: begin
                out_req  = 1'b1;
                out_data = null_byte(byte_cnt_q);
                if (out_ack) begin
                    byte_cnt_d = byte_cnt_q + 8'd1;
                    if (last) begin
                        state_d  = ST_IDLE;
                        null_inc = 1'b1;
                    end
                end
            end
            ST_RESYNC: begin
                // Drop junk; leave the sync byte in the FIFO for PASS.
                in_ack = in_req && !sync_ok;
                if (in_req && sync_ok) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            byte_cnt_q     <= 8'd0;
            null_cnt_q     <= 16'd0;
            sync_err_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            if (null_inc) null_cnt_q <= null_cnt_q + 16'd1;
            if (sync_inc) sync_err_cnt_q <= sync_err_cnt_q + 16'd1;
        end
    end

    assign out_pkt_start = out_req && (byte_cnt_q == 8'd0);
    assign out_is_null   = (state_q == ST_NULL);
    assign null_cnt      = null_cnt_q;
    assign sync_err_cnt  = sync_err_cnt_q;

endmodule

// File: tb/tb_zl_ts_null_inserter.sv
// Scoreboard bench for zl_ts_null_inserter with a behavioural FIFO and
// a packet-level reference model.
module tb_zl_ts_null_inserter;

    localparam int AW  = 9;
    localparam int CAP = 512;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_req = 1'b0;
    logic          in_ack;
    logic [7:0]    in_data = 8'h00;
    logic [AW-1:0] in_used = '0;
    logic          in_full = 1'b0;
    logic          out_req;
    logic          out_ack = 1'b0;
    logic [7:0]    out_data;
    logic          out_pkt_start;
    logic          out_is_null;
    logic [15:0]   null_cnt;
    logic [15:0]   sync_err_cnt;

    zl_ts_null_inserter #(.Addr_width(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
        .in_used(in_used), .in_full(in_full),
        .out_req(out_req), .out_ack(out_ack), .out_data(out_data),
        .out_pkt_start(out_pkt_start), .out_is_null(out_is_null),
        .null_cnt(null_cnt), .sync_err_cnt(sync_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       s;
        logic       n;
    } exp_t;

    typedef enum {M_DECIDE, M_PKT, M_BAD, M_HUNT} mmode_e;

    exp_t       exp_q[$];
    logic [7:0] fq[$];
    logic [7:0] wr_q[$];
    mmode_e     mode = M_DECIDE;
    bit         m_pass = 1'b0;
    int         m_pos = 0;
    logic [15:0] m_null = 16'd0;
    logic [15:0] m_sync = 16'd0;
    int         n_cmp = 0;
    int         n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
        end
    endtask

    function automatic logic [7:0] null_ref(input int i);
        if (i == 0) return 8'h47;
        if (i == 1) return 8'h1F;
        if (i == 2) return 8'hFF;
        if (i == 3) return 8'h10;
        return 8'hFF;
    endfunction

    function automatic logic [7:0] junk();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'h47) b = 8'h00;
        return b;
    endfunction

    task automatic push_pkt(input bit rnd);
        wr_q.push_back(8'h47);
        for (int i = 0; i < 187; i++)
            wr_q.push_back(rnd ? 8'($urandom) : 8'(i));
    endtask

    // Show-ahead FIFO read port, with a registered fill count.
    always @(posedge clk) begin
        #1;
        in_req  = (fq.size() > 0);
        in_data = (fq.size() > 0) ? fq[0] : 8'($urandom);
        in_used = AW'(fq.size());
        in_full = (fq.size() == CAP);
    end

    // Reference model: decides each packet from the buffered level and
    // queues the bytes that packet must produce.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs",
                {out_req, in_ack, out_pkt_start, out_is_null, out_data},
                32'd0);
            chk("reset_counters", {null_cnt, sync_err_cnt}, 32'd0);
            fq.delete();
            exp_q.delete();
            mode   = M_DECIDE;
            m_pos  = 0;
            m_null = 16'd0;
            m_sync = 16'd0;
        end else begin
            if (in_ack && !in_req) chk("ack_without_req", in_ack, 0);
            case (mode)
                M_DECIDE: begin
                    chk("null_cnt", null_cnt, m_null);
                    chk("sync_err_cnt", sync_err_cnt, m_sync);
                    chk("idle_quiet", {out_req, in_ack}, 0);
                    m_pos = 0;
                    if (fq.size() >= 188 && fq[0] == 8'h47) begin
                        for (int i = 0; i < 188; i++)
                            exp_q.push_back(exp_t'{d: fq[i], s: (i == 0), n: 1'b0});
                        m_pass = 1'b1;
                        mode   = M_PKT;
                    end else if (fq.size() >= 188) begin
                        m_sync++;
                        mode = M_BAD;
                    end else begin
                        for (int i = 0; i < 188; i++)
                            exp_q.push_back(exp_t'{d: null_ref(i), s: (i == 0), n: 1'b1});
                        m_pass = 1'b0;
                        mode   = M_PKT;
                    end
                end
                M_PKT: begin
                    chk("out_req_in_pkt", out_req,
                        m_pass ? 32'(fq.size() > 0) : 32'd1);
                    if (!m_pass) chk("null_no_ack", in_ack, 0);
                    if (out_req && out_ack) begin
                        m_pos++;
                        if (m_pos == 188) begin
                            mode = M_DECIDE;
                            if (!m_pass) m_null++;
                        end
                    end
                end
                M_BAD: begin
                    chk("bad_sync_hold", {out_req, in_ack}, 0);
                    mode = M_HUNT;
                end
                M_HUNT: begin
                    chk("resync_no_out", out_req, 0);
                    chk("resync_ack", in_ack,
                        32'(fq.size() > 0 && fq[0] != 8'h47));
                    if (fq.size() > 0 && fq[0] == 8'h47) mode = M_DECIDE;
                end
                default: mode = M_DECIDE;
            endcase
            if (in_ack && fq.size() > 0) void'(fq.pop_front());
        end
        while (wr_q.size() > 0 && fq.size() < CAP)
            fq.push_back(wr_q.pop_front());
    end

    // Monitor: every accepted output byte is checked against the queue.
    always @(negedge clk) begin
        if (rst_n && out_req && out_ack) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", {out_data, out_pkt_start, out_is_null},
                    32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_byte", {out_data, out_pkt_start, out_is_null}, 32'(e));
            end
        end
    end

    initial begin
        bit ok;
        logic [7:0] third[$];
        rst_n   = 1'b0;
        out_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        push_pkt(1'b0);
        push_pkt(1'b0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        out_ack = 1'b1;

        // Two preloaded packets, then an empty FIFO running on nulls.
        repeat (800) @(posedge clk);

        // 187 bytes buffered, the last byte arrives during a null packet.
        #1;
        wr_q.push_back(8'h47);
        for (int i = 0; i < 186; i++) wr_q.push_back(8'(i + 3));
        repeat (60) @(posedge clk);
        #1;
        wr_q.push_back(8'hA5);
        repeat (450) @(posedge clk);

        // Lost sync: 0x00 + five junk bytes ahead of a valid packet.
        #1;
        wr_q.push_back(8'h00);
        for (int i = 1; i <= 5; i++) wr_q.push_back(8'(i * 8'h11));
        push_pkt(1'b0);
        repeat (600) @(posedge clk);

        // Random backpressure with random packet arrivals and junk.
        for (int c = 0; c < 3000; c++) begin
            #1;
            out_ack = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0 && fq.size() + wr_q.size() < 300) begin
                if ($urandom_range(0, 3) == 0)
                    for (int j = 0; j < $urandom_range(1, 3); j++)
                        wr_q.push_back(junk());
                push_pkt(1'b1);
            end
            @(posedge clk);
        end

        // Drain, then fill the FIFO to the brim while a null is stalled.
        #1;
        out_ack = 1'b1;
        repeat (1200) @(posedge clk);
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            if (mode == M_PKT && !m_pass && m_pos < 150) begin
                ok = 1'b1;
                break;
            end
        end
        chk("full_setup_found", ok, 1);
        out_ack = 1'b0;
        push_pkt(1'b1);
        push_pkt(1'b1);
        third.push_back(8'h47);
        for (int i = 0; i < 187; i++) third.push_back(8'($urandom));
        for (int i = 0; i < 136; i++) wr_q.push_back(third[i]);
        repeat (3) @(posedge clk);
        #1;
        out_ack = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        for (int i = 136; i < 188; i++) wr_q.push_back(third[i]);
        repeat (900) @(posedge clk);

        // Reset in the middle of a forwarded packet.
        #1;
        push_pkt(1'b1);
        push_pkt(1'b1);
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            #1;
            if (mode == M_PKT && m_pass && m_pos == 90) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reset_trigger_found", ok, 1);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (250) @(posedge clk);
        #1;
        push_pkt(1'b1);
        repeat (500) @(posedge clk);

        chk("scoreboard_backlog", 32'(exp_q.size() <= 188), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/zl_ts_null_inserter.md
# zl_ts_null_inserter

Packet-aligned consumer on the read side of the TS byte FIFO (`zl_fifo_sc`, show-ahead). The block forwards whole 188-byte transport stream packets from the FIFO to the downstream encoder chain. It never starts a packet it cannot finish: when less than one full packet is buffered, it emits a DVB null packet instead. This keeps the downstream byte stream continuous and packet-aligned. It also re-acquires the 0x47 sync byte after corrupt input.

## Interface
Parameters:
- `Addr_width`, default 0: width of the FIFO `used` count. Must be set ≥ 8.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_req`  in  1  FIFO has a byte (FIFO `out_req`).
- `in_ack`  out  1  byte consumed (to FIFO `out_ack`).
- `in_data`  in  8  FIFO head byte, valid while `in_req`.
- `in_used`  in  Addr_width  FIFO fill count.
- `in_full`  in  1  FIFO full; qualifies a wrapped `in_used`.
- `out_req`  out  1  output byte valid.
- `out_ack`  in  1  downstream accepts the byte.
- `out_data`  out  8  output byte.
- `out_pkt_start`  out  1  `out_data` is byte 0 of a packet.
- `out_is_null`  out  1  current byte belongs to an inserted null packet.
- `null_cnt`  out  16  inserted null packets; wraps.
- `sync_err_cnt`  out  16  sync-loss events; wraps.

## Operation
- Handshake on both sides: a transfer occurs in any cycle where req && ack are both high. Data is held stable while req is high and ack is low.
- FSM states: IDLE, PASS, NULL, RESYNC. `byte_cnt` is 8 bits and runs 0..187.
- **IDLE** (one cycle, `out_req` = 0):
  - `avail` = `in_full` || (`in_used` ≥ 188).
  - If `avail`, go to PASS; otherwise go to NULL.
  - `byte_cnt` is cleared to 0.
- **PASS**:
  - `out_req` = `in_req`; `out_data` = `in_data`; `in_ack` = `in_req` && `out_ack`.
  - These are combinational, giving zero-cycle latency.
  - `byte_cnt` increments on each transfer.
  - After the transfer at `byte_cnt` = 187, go to IDLE.
- **PASS, byte 0 check**: if `in_req` && `in_data` ≠ 0x47, do not forward the byte (`out_req` = 0, `in_ack` = 0). Go to RESYNC and increment `sync_err_cnt`.
- **NULL**:
  - `out_req` = 1; `in_ack` = 0.
  - Output bytes are 0x47, 0x1F, 0xFF, 0x10, then 184 × 0xFF.
  - `byte_cnt` increments on `out_ack`.
  - After the transfer at `byte_cnt` = 187, go to IDLE and increment `null_cnt`.
- **RESYNC**:
  - `out_req` = 0.
  - `in_ack` = `in_req` && (`in_data` ≠ 0x47), so non-sync bytes are discarded.
  - When `in_req` && `in_data` = 0x47, go to IDLE without consuming that byte.
- `out_pkt_start` = `out_req` && (`byte_cnt` = 0). `out_is_null` = (state = NULL).
- A `in_req` drop inside PASS stalls the output only; the byte count is preserved and no null bytes are spliced in.
- Packets are atomic: once PASS or NULL has started, the packet completes regardless of FIFO level changes.

## Timing
- Reset (async assert): state = IDLE, `byte_cnt` = 0, `null_cnt` = 0, `sync_err_cnt` = 0.
  - Outputs under reset: `out_req` = 0, `in_ack` = 0, `out_pkt_start` = 0, `out_is_null` = 0, `out_data` = 0.
  - `rst_n` is shared with the FIFO. Reset mid-packet abandons the packet; the first post-reset output is a fresh packet decision.
- PASS latency is 0 cycles input-to-output. Throughput is 188 bytes per 189 cycles at best (one IDLE bubble per packet).
- The IDLE decision uses `in_used` one cycle after the last read. This is valid because the FIFO `used` count is registered.
- `in_used` wraps to 0 at 2**Addr_width entries; `in_full` covers that case.
- Simultaneous: `out_ack` low in NULL holds the byte and `byte_cnt`. The counter increment and the state change happen on the same edge.

## Structure
- Shared TS definitions package/header `zl_ts_defs`:
  - TS_SYNC = 8'h47, TS_PKT_LEN = 188.
  - Null header bytes 8'h1F, 8'hFF, 8'h10; null fill byte 8'hFF.
  - State encodings.
- Single module, no sub-module. The null byte generator is a 4-entry mux on `byte_cnt` plus a fill default.

## Test plan
- FIFO preloaded with 2 valid packets (first byte 0x47, payload 0..186), `out_ack` = 1 → 376 bytes out in order. `out_pkt_start` pulses at bytes 0 and 188, with one idle cycle between packets. `null_cnt` = 0.
- Empty FIFO, `out_ack` = 1 → continuous null packets 47 1F FF 10 FF…. `null_cnt` increments every 189 cycles. `in_ack` is never high.
- FIFO holds 187 bytes → null packet emitted. Write 1 more byte during the null packet → next packet is PASS.
- Packet whose first byte is 0x00, followed by 5 junk bytes then 0x47 and a valid packet → `sync_err_cnt` = 1. The 6 bytes are discarded, then the valid packet passes.
- Random `out_ack` backpressure during PASS and NULL → no lost or duplicated bytes; output is compared against the model.
- `rst_n` pulsed at byte 90 of a PASS packet → all outputs 0 during reset. Post-reset output starts with a new packet boundary.
